// File: rtl/move_merge_engine.sv
// Sequential NxN 2048 move/merge engine: one row or column is slid and merged per
// cycle, then the new board, gained score, moved and win flags are presented with done.
module move_merge_engine #(
    parameter int N = 4,
    parameter int TILE_W = 12,
    parameter int SCORE_W = 20,
    parameter logic [TILE_W-1:0] WIN_VALUE = TILE_W'(12'h800)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [3:0]               direction,
    input  logic [N*N*TILE_W-1:0]    board_in,
    output logic                     busy,
    output logic                     done,
    output logic [N*N*TILE_W-1:0]    board_out,
    output logic [SCORE_W-1:0]       score_update,
    output logic                     moved,
    output logic                     win,
    output logic [1:0]               state_dbg
);

    // Handshake: start is accepted on any cycle where busy is low (IDLE or DONE);
    // done pulses for exactly one cycle and board_out/score_update/moved/win are
    // valid from that cycle on and held until the next done or reset.

    localparam int BOARD_W = N * N * TILE_W;
    localparam int LINE_W  = (N > 1) ? $clog2(N) : 1;
    localparam int POS_W   = $clog2(N + 1);
    localparam int GAIN_W  = TILE_W + $clog2(N);
    localparam int SUM_W   = ((SCORE_W > GAIN_W) ? SCORE_W : GAIN_W) + 1;
    localparam logic [TILE_W-1:0]  TOP_TILE  = {1'b1, {(TILE_W-1){1'b0}}};
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LINE = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [BOARD_W-1:0]  work;
    logic [BOARD_W-1:0]  orig;
    logic [3:0]          dir_q;
    logic [LINE_W-1:0]   line_idx;
    logic [SCORE_W-1:0]  acc;

    logic                accept;
    logic                last_line;
    logic                dir_ok;
    logic [N*TILE_W-1:0] line_in;
    logic [N*TILE_W-1:0] line_out;
    logic [TILE_W-1:0]   tile;
    logic [TILE_W-1:0]   pend;
    logic [POS_W-1:0]    pos;
    logic [GAIN_W-1:0]   gain;
    logic [GAIN_W-1:0]   gain_eff;
    logic [SUM_W-1:0]    sum;
    logic [SCORE_W-1:0]  acc_next;
    logic [BOARD_W-1:0]  work_next;
    logic                win_next;

    // Flat tile index of position i (counted from the leading end) within line k.
    function automatic int tile_pos(input logic [3:0] dir, input int k, input int i);
        int r;
        int c;
        r = k;
        c = i;
        if (dir[0]) begin
            r = i;
            c = k;
        end else if (dir[1]) begin
            r = N - 1 - i;
            c = k;
        end else if (dir[3]) begin
            r = k;
            c = N - 1 - i;
        end
        return r * N + c;
    endfunction

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = start && (state != S_LINE);
        last_line  = (line_idx == LINE_W'(N - 1));
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_LINE;
                end
            end
            S_LINE: begin
                busy = 1'b1;
                if (last_line) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = accept ? S_LINE : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign state_dbg = state;

    // ---------------- line extraction ----------------
    always_comb begin
        dir_ok  = (dir_q != 4'b0000) && ((dir_q & (dir_q - 4'd1)) == 4'b0000);
        line_in = '0;
        for (int i = 0; i < N; i++) begin
            line_in[i*TILE_W +: TILE_W] =
                work[tile_pos(dir_q, int'(line_idx), i)*TILE_W +: TILE_W];
        end
    end

    // Single pass slide/merge: a held tile either merges with the next non-zero
    // tile or is emitted, so each tile merges at most once and output stays compact.
    always_comb begin
        line_out = '0;
        tile     = '0;
        pend     = '0;
        pos      = '0;
        gain     = '0;
        for (int i = 0; i < N; i++) begin
            tile = line_in[i*TILE_W +: TILE_W];
            if (tile != '0) begin
                if ((pend == tile) && (tile != TOP_TILE)) begin
                    line_out[int'(pos)*TILE_W +: TILE_W] = {tile[TILE_W-2:0], 1'b0};
                    gain = gain + GAIN_W'({tile[TILE_W-2:0], 1'b0});
                    pos  = pos + POS_W'(1);
                    pend = '0;
                end else begin
                    if (pend != '0) begin
                        line_out[int'(pos)*TILE_W +: TILE_W] = pend;
                        pos = pos + POS_W'(1);
                    end
                    pend = tile;
                end
            end
        end
        if (pend != '0) begin
            line_out[int'(pos)*TILE_W +: TILE_W] = pend;
        end
    end

    // ---------------- write-back, score and win ----------------
    always_comb begin
        work_next = work;
        if (dir_ok) begin
            for (int i = 0; i < N; i++) begin
                work_next[tile_pos(dir_q, int'(line_idx), i)*TILE_W +: TILE_W] =
                    line_out[i*TILE_W +: TILE_W];
            end
        end
        gain_eff = dir_ok ? gain : '0;
        sum      = SUM_W'(acc) + SUM_W'(gain_eff);
        acc_next = (sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : sum[SCORE_W-1:0];
        win_next = 1'b0;
        for (int t = 0; t < N * N; t++) begin
            if (work_next[t*TILE_W +: TILE_W] == WIN_VALUE) begin
                win_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work         <= '0;
            orig         <= '0;
            dir_q        <= '0;
            line_idx     <= '0;
            acc          <= '0;
            board_out    <= '0;
            score_update <= '0;
            moved        <= 1'b0;
            win          <= 1'b0;
        end else begin
            if (accept) begin
                work     <= board_in;
                orig     <= board_in;
                dir_q    <= direction;
                line_idx <= '0;
                acc      <= '0;
            end else if (state == S_LINE) begin
                work     <= work_next;
                acc      <= acc_next;
                line_idx <= line_idx + LINE_W'(1);
                // Results land on the last line so they are visible during DONE.
                if (last_line) begin
                    board_out    <= work_next;
                    score_update <= acc_next;
                    moved        <= (work_next != orig);
                    win          <= win_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_move_merge_engine.sv
// Bench for move_merge_engine: directed vector table, multi-cycle corner sequences
// and randomized moves checked against a queue-based reference model.
module tb_move_merge_engine;

    localparam int N       = 4;
    localparam int TILE_W  = 12;
    localparam int SCORE_W = 20;
    localparam int BW      = N * N * TILE_W;
    localparam int RW      = N * TILE_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [3:0]        direction = 4'b0000;
    logic [BW-1:0]     board_in = '0;
    logic              busy;
    logic              done;
    logic [BW-1:0]     board_out;
    logic [SCORE_W-1:0] score_update;
    logic              moved;
    logic              win;
    logic [1:0]        state_dbg;

    int tests = 0;
    int fails = 0;

    logic [BW-1:0]      exp_q[$];
    logic [SCORE_W-1:0] exp_score_q[$];
    logic [1:0]         exp_flag_q[$];

    move_merge_engine #(
        .N(N), .TILE_W(TILE_W), .SCORE_W(SCORE_W), .WIN_VALUE(12'h800)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .direction(direction),
        .board_in(board_in), .busy(busy), .done(done), .board_out(board_out),
        .score_update(score_update), .moved(moved), .win(win), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] mkrow(input int a, input int b, input int c, input int d);
        return {TILE_W'(d), TILE_W'(c), TILE_W'(b), TILE_W'(a)};
    endfunction

    function automatic logic [BW-1:0] mkbrd(input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                                            input logic [RW-1:0] r2, input logic [RW-1:0] r3);
        return {r3, r2, r1, r0};
    endfunction

    // Reference: gather non-zero tiles from the leading end into a queue, pair equal
    // neighbours left to right, pad with zeros, scatter back.
    function automatic void ref_move(input logic [BW-1:0] b, input logic [3:0] d,
                                     output logic [BW-1:0] ob, output logic [SCORE_W-1:0] sc,
                                     output logic mv, output logic wn);
        int g[N][N];
        int q[$];
        int o[$];
        int total;
        int r;
        int c;
        int j;
        for (int rr = 0; rr < N; rr++)
            for (int cc = 0; cc < N; cc++)
                g[rr][cc] = int'(b[(rr*N+cc)*TILE_W +: TILE_W]);
        total = 0;
        if (d == 4'b0001 || d == 4'b0010 || d == 4'b0100 || d == 4'b1000) begin
            for (int k = 0; k < N; k++) begin
                q.delete();
                for (int i = 0; i < N; i++) begin
                    case (d)
                        4'b0001: begin r = i;         c = k;         end
                        4'b0010: begin r = N - 1 - i; c = k;         end
                        4'b0100: begin r = k;         c = i;         end
                        default: begin r = k;         c = N - 1 - i; end
                    endcase
                    if (g[r][c] != 0) q.push_back(g[r][c]);
                end
                o.delete();
                j = 0;
                while (j < q.size()) begin
                    if (j + 1 < q.size() && q[j] == q[j+1] && q[j] != 2048) begin
                        o.push_back(2 * q[j]);
                        total += 2 * q[j];
                        j += 2;
                    end else begin
                        o.push_back(q[j]);
                        j += 1;
                    end
                end
                for (int i = 0; i < N; i++) begin
                    case (d)
                        4'b0001: begin r = i;         c = k;         end
                        4'b0010: begin r = N - 1 - i; c = k;         end
                        4'b0100: begin r = k;         c = i;         end
                        default: begin r = k;         c = N - 1 - i; end
                    endcase
                    g[r][c] = (i < o.size()) ? o[i] : 0;
                end
            end
        end
        ob = '0;
        wn = 1'b0;
        for (int rr = 0; rr < N; rr++)
            for (int cc = 0; cc < N; cc++) begin
                ob[(rr*N+cc)*TILE_W +: TILE_W] = TILE_W'(g[rr][cc]);
                if (g[rr][cc] == 2048) wn = 1'b1;
            end
        sc = (total > 20'hFFFFF) ? 20'hFFFFF : SCORE_W'(total);
        mv = (ob != b);
    endfunction

    function automatic int rand_tile();
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel < 4) return 0;
        if (sel == 9) return 1 << $urandom_range(9, 11);
        return 1 << $urandom_range(1, 3);
    endfunction

    // ---------------- driver ----------------
    // Returns at the falling edge where done is seen; lat counts falling edges after
    // the rising edge that sampled start.
    task automatic run_move(input logic [BW-1:0] b, input logic [3:0] d, input bit b2b,
                            output int lat, output logic busy1);
        if (!b2b) @(negedge clk);
        board_in  = b;
        direction = d;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        busy1 = busy;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        string              name;
        logic [BW-1:0]      b;
        logic [3:0]         d;
        logic [BW-1:0]      eb;
        logic [SCORE_W-1:0] es;
        logic               em;
        logic               ew;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [BW-1:0]      b1;
        logic [BW-1:0]      rb;
        logic [BW-1:0]      eb;
        logic [SCORE_W-1:0] es;
        logic               em;
        logic               ew;
        logic [3:0]         rd;
        logic [BW-1:0]      cap_board;
        int                 lat;
        int                 dones;
        logic               busy1;
        logic [1:0]         fl;

        b1 = mkbrd(mkrow(2,2,4,4), mkrow(2,2,4,4), mkrow(0,0,4,0), mkrow(0,0,4,0));
        vecs.push_back('{"up_board1", b1, 4'b0001,
            mkbrd(mkrow(4,4,8,8), mkrow(0,0,8,0), mkrow(0,0,0,0), mkrow(0,0,0,0)), 20'h20, 1'b1, 1'b0});
        vecs.push_back('{"down_board1", b1, 4'b0010,
            mkbrd(mkrow(0,0,0,0), mkrow(0,0,0,0), mkrow(0,0,8,0), mkrow(4,4,8,8)), 20'h20, 1'b1, 1'b0});
        vecs.push_back('{"left_2222", mkbrd(mkrow(2,2,2,2), '0, '0, '0), 4'b0100,
            mkbrd(mkrow(4,4,0,0), '0, '0, '0), 20'd8, 1'b1, 1'b0});
        vecs.push_back('{"right_2222", mkbrd(mkrow(2,2,2,2), '0, '0, '0), 4'b1000,
            mkbrd(mkrow(0,0,4,4), '0, '0, '0), 20'd8, 1'b1, 1'b0});
        vecs.push_back('{"left_2024", mkbrd(mkrow(2,0,2,4), '0, '0, '0), 4'b0100,
            mkbrd(mkrow(4,4,0,0), '0, '0, '0), 20'd4, 1'b1, 1'b0});
        vecs.push_back('{"left_4480", mkbrd(mkrow(4,4,8,0), '0, '0, '0), 4'b0100,
            mkbrd(mkrow(8,8,0,0), '0, '0, '0), 20'd8, 1'b1, 1'b0});
        vecs.push_back('{"left_nomove", mkbrd(mkrow(2,4,8,16), '0, '0, '0), 4'b0100,
            mkbrd(mkrow(2,4,8,16), '0, '0, '0), 20'd0, 1'b0, 1'b0});
        vecs.push_back('{"dir_0011", b1, 4'b0011, b1, 20'd0, 1'b0, 1'b0});
        vecs.push_back('{"dir_0000", b1, 4'b0000, b1, 20'd0, 1'b0, 1'b0});
        vecs.push_back('{"top_nomerge", mkbrd(mkrow(2048,2048,0,0), '0, '0, '0), 4'b0100,
            mkbrd(mkrow(2048,2048,0,0), '0, '0, '0), 20'd0, 1'b0, 1'b1});
        vecs.push_back('{"win_invalid_dir", mkbrd(mkrow(2048,2048,0,0), '0, '0, '0), 4'b0000,
            mkbrd(mkrow(2048,2048,0,0), '0, '0, '0), 20'd0, 1'b0, 1'b1});
        vecs.push_back('{"merge_to_win", mkbrd(mkrow(1024,1024,0,0), '0, '0, '0), 4'b0100,
            mkbrd(mkrow(2048,0,0,0), '0, '0, '0), 20'h800, 1'b1, 1'b1});

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_busy", BW'(busy), '0);
        check("rst_done", BW'(done), '0);
        check("rst_board", board_out, '0);
        check("rst_score", BW'(score_update), '0);
        check("rst_moved_win", BW'({moved, win}), '0);
        rst_n = 1'b1;

        // ---- directed table ----
        foreach (vecs[v]) begin
            run_move(vecs[v].b, vecs[v].d, 1'b0, lat, busy1);
            check({vecs[v].name, "_latency"}, BW'(lat), BW'(5));
            check({vecs[v].name, "_busy"}, BW'(busy1), BW'(1));
            check({vecs[v].name, "_board"}, board_out, vecs[v].eb);
            check({vecs[v].name, "_score"}, BW'(score_update), BW'(vecs[v].es));
            check({vecs[v].name, "_moved"}, BW'(moved), BW'(vecs[v].em));
            check({vecs[v].name, "_win"}, BW'(win), BW'(vecs[v].ew));
        end

        // ---- back-to-back start in the done cycle ----
        run_move(mkbrd(mkrow(2,2,2,2), '0, '0, '0), 4'b0100, 1'b1, lat, busy1);
        check("b2b_latency", BW'(lat), BW'(5));
        check("b2b_board", board_out, mkbrd(mkrow(4,4,0,0), '0, '0, '0));
        @(negedge clk);
        check("done_one_cycle", BW'(done), '0);

        // ---- start while busy ignored, board_in changes ignored ----
        @(negedge clk);
        board_in  = mkbrd(mkrow(2,2,2,2), '0, '0, '0);
        direction = 4'b0100;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        board_in  = b1;
        direction = 4'b0001;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        cap_board = '0;
        for (int i = 0; i < 14; i++) begin
            if (done) begin
                dones++;
                if (dones == 1) cap_board = board_out;
            end
            @(negedge clk);
        end
        check("busy_start_dones", BW'(dones), BW'(1));
        check("busy_start_board", cap_board, mkbrd(mkrow(4,4,0,0), '0, '0, '0));

        // ---- reset during a move aborts it ----
        run_move(mkbrd(mkrow(1024,1024,0,0), '0, '0, '0), 4'b0100, 1'b0, lat, busy1);
        check("pre_abort_win", BW'(win), BW'(1));
        @(negedge clk);
        board_in  = b1;
        direction = 4'b0001;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", BW'(busy), '0);
        check("abort_done", BW'(done), '0);
        check("abort_board", board_out, '0);
        check("abort_score", BW'(score_update), '0);
        check("abort_moved_win", BW'({moved, win}), '0);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("abort_no_done", BW'(dones), '0);

        // ---- randomized moves against the reference model ----
        for (int n = 0; n < 40; n++) begin
            rb = '0;
            for (int t = 0; t < N * N; t++) rb[t*TILE_W +: TILE_W] = TILE_W'(rand_tile());
            if ($urandom_range(0, 7) == 0) rd = 4'($urandom_range(0, 15));
            else rd = 4'(1 << $urandom_range(0, 3));
            ref_move(rb, rd, eb, es, em, ew);
            exp_q.push_back(eb);
            exp_score_q.push_back(es);
            exp_flag_q.push_back({em, ew});
            run_move(rb, rd, 1'b0, lat, busy1);
            check("rand_latency", BW'(lat), BW'(5));
            eb = exp_q.pop_front();
            es = exp_score_q.pop_front();
            fl = exp_flag_q.pop_front();
            check("rand_board", board_out, eb);
            check("rand_score", BW'(score_update), BW'(es));
            check("rand_moved_win", BW'({moved, win}), BW'(fl));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
